// File: rtl/bus_wr_fifo_if.sv
// Bus-side and stream-side signals of the bus-writable FIFO.
// The slave modport is the FIFO; the master modport is the bus/fabric side.
interface bus_wr_fifo_if;
  logic        i_Bus_CS;
  logic        i_Bus_Wr_Rd_n;
  logic [15:0] i_Bus_Addr8;
  logic [15:0] i_Bus_Wr_Data;
  logic [15:0] o_Bus_Rd_Data;
  logic        o_Bus_Rd_DV;
  logic [15:0] o_Rd_Data;
  logic        o_Rd_DV;
  logic        i_Rd_Ready;
  logic        o_Full;
  logic        o_Empty;

  modport slave (
    input  i_Bus_CS,
    input  i_Bus_Wr_Rd_n,
    input  i_Bus_Addr8,
    input  i_Bus_Wr_Data,
    output o_Bus_Rd_Data,
    output o_Bus_Rd_DV,
    output o_Rd_Data,
    output o_Rd_DV,
    input  i_Rd_Ready,
    output o_Full,
    output o_Empty
  );

  modport master (
    output i_Bus_CS,
    output i_Bus_Wr_Rd_n,
    output i_Bus_Addr8,
    output i_Bus_Wr_Data,
    input  o_Bus_Rd_Data,
    input  o_Bus_Rd_DV,
    input  o_Rd_Data,
    input  o_Rd_DV,
    output i_Rd_Ready,
    input  o_Full,
    input  o_Empty
  );
endinterface

// File: rtl/bus_wr_fifo.sv
// Bus-writable FIFO: bus pushes 16-bit words via a DATA register, fabric drains
// them over a valid/ready port; STATUS/CONTROL registers for count, flush and overflow.
module bus_wr_fifo #(
  parameter int unsigned DEPTH = 256
) (
  input logic          i_Bus_Clk,
  input logic          i_Bus_Rst,
  bus_wr_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full_q, empty_q;
  logic [15:0]   bus_rd_data_q, bus_rd_data_d;
  logic          bus_rd_dv_q;

  logic [1:0]  idx;
  logic        wr_en, rd_en;
  logic        pop, push_req, push_ok, push_drop;
  logic        flush, clr_ovf;
  logic [11:0] count12;
  logic [15:0] status;
  logic        unused_addr;

  assign idx         = bus.i_Bus_Addr8[2:1];
  assign unused_addr = ^{bus.i_Bus_Addr8[15:3], bus.i_Bus_Addr8[0]};
  assign wr_en       = bus.i_Bus_CS & bus.i_Bus_Wr_Rd_n;
  assign rd_en       = bus.i_Bus_CS & ~bus.i_Bus_Wr_Rd_n;

  assign pop       = (count_q != '0) & bus.i_Rd_Ready;
  assign push_req  = wr_en & (idx == 2'd0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req & (~full_q | pop);
  assign push_drop = push_req & ~push_ok;
  assign flush     = wr_en & (idx == 2'd2) & bus.i_Bus_Wr_Data[0];
  assign clr_ovf   = wr_en & (idx == 2'd2) & bus.i_Bus_Wr_Data[1];

  assign count12 = 12'(count_q);
  assign status  = {full_q, empty_q, ovf_q, 1'b0, count12};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
    // Set wins over clear when both occur together.
    if (clr_ovf)   ovf_d = 1'b0;
    if (push_drop) ovf_d = 1'b1;
  end

  always_comb begin
    bus_rd_data_d = bus_rd_data_q;
    if (rd_en) begin
      bus_rd_data_d = (idx == 2'd1) ? status : 16'h0000;
    end
  end

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      bus_rd_data_q <= 16'h0000;
      bus_rd_dv_q   <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      full_q        <= (count_d == CW'(DEPTH));
      empty_q       <= (count_d == '0);
      bus_rd_data_q <= bus_rd_data_d;
      bus_rd_dv_q   <= rd_en;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_Bus_Clk) begin
    if (push_ok && !i_Bus_Rst) begin
      mem[wr_ptr_q] <= bus.i_Bus_Wr_Data;
    end
  end

  assign bus.o_Rd_Data     = mem[rd_ptr_q];
  assign bus.o_Rd_DV       = (count_q != '0);
  assign bus.o_Full        = full_q;
  assign bus.o_Empty       = empty_q;
  assign bus.o_Bus_Rd_Data = bus_rd_data_q;
  assign bus.o_Bus_Rd_DV   = bus_rd_dv_q;

endmodule

// File: tb/tb_bus_wr_fifo.sv
// Directed self-checking bench for bus_wr_fifo at DEPTH=4.
module tb_bus_wr_fifo;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bus_wr_fifo_if bus_if ();

  bus_wr_fifo #(
    .DEPTH (4)
  ) u_dut (
    .i_Bus_Clk (clk),
    .i_Bus_Rst (rst),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [15:0] data);
    bus_if.i_Bus_CS      = 1'b1;
    bus_if.i_Bus_Wr_Rd_n = 1'b1;
    bus_if.i_Bus_Addr8   = addr;
    bus_if.i_Bus_Wr_Data = data;
    tick();
    bus_if.i_Bus_CS      = 1'b0;
  endtask

  task automatic read_chk(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    bus_if.i_Bus_CS      = 1'b1;
    bus_if.i_Bus_Wr_Rd_n = 1'b0;
    bus_if.i_Bus_Addr8   = addr;
    tick();
    bus_if.i_Bus_CS      = 1'b0;
    check_eq({tag, "_dv"}, 16'(bus_if.o_Bus_Rd_DV), 16'd1);
    check_eq(tag, bus_if.o_Bus_Rd_Data, exp);
    tick();
    check_eq({tag, "_dv_end"}, 16'(bus_if.o_Bus_Rd_DV), 16'd0);
  endtask

  initial begin
    logic [15:0] q [$];
    logic [15:0] word;
    int          pushed;
    int          popped;
    int          cyc;
    logic        do_pop;
    logic        do_push;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_if.i_Bus_CS      = 1'b0;
    bus_if.i_Bus_Wr_Rd_n = 1'b0;
    bus_if.i_Bus_Addr8   = 16'h0000;
    bus_if.i_Bus_Wr_Data = 16'h0000;
    bus_if.i_Rd_Ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_empty", 16'(bus_if.o_Empty), 16'd1);
    check_eq("rst_full", 16'(bus_if.o_Full), 16'd0);
    check_eq("rst_rd_dv", 16'(bus_if.o_Rd_DV), 16'd0);
    check_eq("rst_bus_dv", 16'(bus_if.o_Bus_Rd_DV), 16'd0);
    check_eq("rst_bus_data", bus_if.o_Bus_Rd_Data, 16'h0000);
    read_chk(16'h0002, 16'h4000, "rst_status");

    // Three pushes, then drain in order
    bus_wr(16'h0000, 16'h1111);
    bus_wr(16'h0000, 16'h2222);
    bus_wr(16'h0000, 16'h3333);
    read_chk(16'h0002, 16'h0003, "st3_status");
    read_chk(16'h0000, 16'h0000, "data_reg_read");
    read_chk(16'h0006, 16'h0000, "reserved_read");
    check_eq("st3_head", bus_if.o_Rd_Data, 16'h1111);
    bus_if.i_Rd_Ready = 1'b1;
    check_eq("drain0", bus_if.o_Rd_Data, 16'h1111);
    tick();
    check_eq("drain1", bus_if.o_Rd_Data, 16'h2222);
    tick();
    check_eq("drain2", bus_if.o_Rd_Data, 16'h3333);
    check_eq("drain2_dv", 16'(bus_if.o_Rd_DV), 16'd1);
    tick();
    bus_if.i_Rd_Ready = 1'b0;
    check_eq("drained_dv", 16'(bus_if.o_Rd_DV), 16'd0);
    read_chk(16'h0002, 16'h4000, "drained_status");

    // Overfill: fifth word dropped, overflow sticky, then cleared
    for (int i = 0; i < 5; i++) bus_wr(16'h0000, 16'(16'h00A0 + i));
    read_chk(16'h0002, 16'hA004, "ovf_status");
    check_eq("ovf_full", 16'(bus_if.o_Full), 16'd1);
    check_eq("ovf_head", bus_if.o_Rd_Data, 16'h00A0);
    bus_wr(16'h0004, 16'h0002);
    read_chk(16'h0002, 16'h8004, "clr_status");

    // Full with pop and push together
    bus_if.i_Rd_Ready = 1'b1;
    bus_wr(16'h0000, 16'hBEEF);
    bus_if.i_Rd_Ready = 1'b0;
    read_chk(16'h0002, 16'h8004, "fullpp_status");
    bus_if.i_Rd_Ready = 1'b1;
    check_eq("fullpp_h0", bus_if.o_Rd_Data, 16'h00A1);
    tick();
    check_eq("fullpp_h1", bus_if.o_Rd_Data, 16'h00A2);
    tick();
    check_eq("fullpp_h2", bus_if.o_Rd_Data, 16'h00A3);
    tick();
    check_eq("fullpp_h3", bus_if.o_Rd_Data, 16'hBEEF);
    tick();
    bus_if.i_Rd_Ready = 1'b0;
    check_eq("fullpp_dv", 16'(bus_if.o_Rd_DV), 16'd0);

    // Flush overrides concurrent pop
    for (int i = 0; i < 3; i++) bus_wr(16'h0000, 16'(16'h0C01 + i));
    bus_if.i_Rd_Ready = 1'b1;
    bus_wr(16'h0004, 16'h0001);
    bus_if.i_Rd_Ready = 1'b0;
    check_eq("flush_dv", 16'(bus_if.o_Rd_DV), 16'd0);
    read_chk(16'h0002, 16'h4000, "flush_status");
    bus_wr(16'h0000, 16'h5555);
    check_eq("flush_push_dv", 16'(bus_if.o_Rd_DV), 16'd1);
    check_eq("flush_push_head", bus_if.o_Rd_Data, 16'h5555);

    // Flush leaves overflow set; clear drops it
    for (int i = 0; i < 4; i++) bus_wr(16'h0000, 16'(16'h0D00 + i));
    read_chk(16'h0002, 16'hA004, "ovf2_status");
    bus_wr(16'h0004, 16'h0001);
    read_chk(16'h0002, 16'h6000, "flush_keep_ovf");
    bus_wr(16'h0004, 16'h0002);
    read_chk(16'h0002, 16'h4000, "ovf2_cleared");

    // Interleaved push/pop across pointer wrap, checked against a queue model
    pushed = 0;
    popped = 0;
    cyc    = 0;
    while ((pushed < 10 || q.size() > 0) && cyc < 60) begin
      bus_if.i_Rd_Ready = (cyc % 3 != 1) || (pushed == 10);
      do_pop  = (q.size() > 0) && bus_if.i_Rd_Ready;
      do_push = (pushed < 10) && ((q.size() < 4) || do_pop);
      check_eq("wrap_dv", 16'(bus_if.o_Rd_DV), 16'(q.size() > 0));
      check_eq("wrap_full", 16'(bus_if.o_Full), 16'(q.size() == 4));
      if (do_pop) check_eq("wrap_head", bus_if.o_Rd_Data, q[0]);
      word = 16'(16'h7000 + pushed);
      bus_if.i_Bus_CS      = do_push;
      bus_if.i_Bus_Wr_Rd_n = 1'b1;
      bus_if.i_Bus_Addr8   = 16'h0000;
      bus_if.i_Bus_Wr_Data = word;
      tick();
      bus_if.i_Bus_CS = 1'b0;
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (do_push) begin
        q.push_back(word);
        pushed++;
      end
      cyc++;
    end
    bus_if.i_Rd_Ready = 1'b0;
    check_eq("wrap_popped", 16'(popped), 16'd10);
    read_chk(16'h0002, 16'h4000, "wrap_status");

    // Reset with words buffered
    bus_wr(16'h0000, 16'h0E01);
    bus_wr(16'h0000, 16'h0E02);
    check_eq("pre_rst_dv", 16'(bus_if.o_Rd_DV), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_dv", 16'(bus_if.o_Rd_DV), 16'd0);
    check_eq("mid_rst_empty", 16'(bus_if.o_Empty), 16'd1);
    read_chk(16'h0002, 16'h4000, "mid_rst_status");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
